trig_sequencer: RTL and testbench

- Programmable trigger-pulse sequencer that sequences the trigger timebase, replacing the fixed-ratio square-wave divider.
- Generates a burst of N pulses on o_trig after a start handshake. Per-run settings: start delay, high time and period, all counted in i_clk cycles.
- Sits between the control/register logic and the downstream trigger outputs.
- Reports busy/done status back to the controller.

---
 rtl/trig_pkg.sv | 14 +
 rtl/trig_sequencer_if.sv | 27 ++
 rtl/trig_phase_cnt.sv | 22 ++
 rtl/trig_sequencer.sv | 121 ++++++++++++
 tb/tb_trig_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared widths, reset defaults and FSM state encoding for the trigger sequencer
package trig_pkg;
    localparam int TRIG_CNT_W      = 26;
    localparam int TRIG_BURST_W    = 16;
    localparam int TRIG_DEF_PERIOD = 2_500_000;
    localparam int TRIG_DEF_HIGH   = 1_250_000;
    localparam int TRIG_DEF_DELAY  = 0;
    localparam int TRIG_DEF_BURST  = 0;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DELAY = 2'd1;
    localparam state_t ST_HIGH  = 2'd2;
    localparam state_t ST_LOW   = 2'd3;
endpackage

// File: rtl/trig_sequencer_if.sv
// trig_sequencer_if: config, start/abort handshake and status bus between controller and sequencer
interface trig_sequencer_if
    import trig_pkg::*;
#(
    parameter int CNT_W   = TRIG_CNT_W,
    parameter int BURST_W = TRIG_BURST_W
);
    logic               cfg_we;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [CNT_W-1:0]   cfg_delay;
    logic [BURST_W-1:0] cfg_burst;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               o_trig;
    logic [BURST_W-1:0] pulse_idx;
    modport master (
        output cfg_we, cfg_period, cfg_high, cfg_delay, cfg_burst, start, abort,
        input  busy, done, o_trig, pulse_idx
    );
    modport slave (
        input  cfg_we, cfg_period, cfg_high, cfg_delay, cfg_burst, start, abort,
        output busy, done, o_trig, pulse_idx
    );
endinterface

// File: rtl/trig_phase_cnt.sv
// trig_phase_cnt: loadable down-counter timing one sequencer phase; last_o marks the phase's final cycle
module trig_phase_cnt
    import trig_pkg::*;
#(
    parameter int CNT_W = TRIG_CNT_W
)(
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d  = load_i ? val_i : en_i ? cnt_q - CNT_W'(1) : cnt_q;
    assign last_o = cnt_q == CNT_W'(1);
    // phase counter register
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/trig_sequencer.sv
// trig_sequencer: programmable delay/high/period burst generator on o_trig; TRIG_EXT_START_EN adds a synchronized ext_trig start
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int CNT_W      = TRIG_CNT_W,
    parameter int BURST_W    = TRIG_BURST_W,
    parameter int DEF_PERIOD = TRIG_DEF_PERIOD,
    parameter int DEF_HIGH   = TRIG_DEF_HIGH,
    parameter int DEF_DELAY  = TRIG_DEF_DELAY,
    parameter int DEF_BURST  = TRIG_DEF_BURST
)(
    input logic i_clk,
    input logic rst_n,
`ifdef TRIG_EXT_START_EN
    input logic ext_trig,
`endif
    trig_sequencer_if.slave bus
);
    // High time is capped one below all-ones so that H+1 (the minimum period) always fits
    localparam logic [CNT_W-1:0] H_MAX = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam int DEF_H = DEF_HIGH < 1 ? 1 : DEF_HIGH;
    localparam int DEF_L = (DEF_PERIOD > DEF_H ? DEF_PERIOD : DEF_H + 1) - DEF_H;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   high_q, high_d, low_q, low_d, delay_q, delay_d;
    logic [BURST_W-1:0] burst_q, burst_d, idx_q, idx_d;
    logic [CNT_W-1:0]   h_cl, p_cl, load_val;
    logic               busy_q, done_q, done_d, trig_q;
    logic               idle, we, accept, start_eff, cnt_load, cnt_last;
`ifdef TRIG_EXT_START_EN
    logic [2:0] ext_q;
    // two synchronizer flops plus one history flop for rising-edge detection
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) ext_q <= '0;
        else        ext_q <= {ext_q[1:0], ext_trig};
    end
    assign start_eff = bus.start | (ext_q[1] & ~ext_q[2]);
`else
    assign start_eff = bus.start;
`endif
    assign idle    = state_q == ST_IDLE;
    assign we      = bus.cfg_we & idle;
    assign accept  = idle & start_eff & ~bus.abort;
    assign h_cl    = bus.cfg_high == '0 ? CNT_W'(1) : bus.cfg_high > H_MAX ? H_MAX : bus.cfg_high;
    assign p_cl    = bus.cfg_period > h_cl ? bus.cfg_period : h_cl + CNT_W'(1);
    assign high_d  = we ? h_cl : high_q;
    assign low_d   = we ? p_cl - h_cl : low_q;
    assign delay_d = we ? bus.cfg_delay : delay_q;
    assign burst_d = we ? bus.cfg_burst : burst_q;
    // next state: a config written alongside an accepted start already applies to that run
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        load_val = high_q;
        if (idle) begin
            if (accept) begin
                cnt_load = 1'b1;
                idx_d    = '0;
                state_d  = delay_d != '0 ? ST_DELAY : ST_HIGH;
                load_val = delay_d != '0 ? delay_d : high_d;
            end
        end else if (bus.abort) begin
            state_d = ST_IDLE;
        end else if (cnt_last) begin
            cnt_load = 1'b1;
            case (state_q)
                ST_DELAY: state_d = ST_HIGH;
                ST_HIGH: begin
                    state_d  = ST_LOW;
                    load_val = low_q;
                end
                default: begin
                    if (burst_q == '0 || idx_q != burst_q - BURST_W'(1)) begin
                        state_d = ST_HIGH;
                        idx_d   = idx_q + BURST_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end
    // state, shadow config and registered outputs
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            high_q  <= CNT_W'(DEF_H);
            low_q   <= CNT_W'(DEF_L);
            delay_q <= CNT_W'(DEF_DELAY);
            burst_q <= BURST_W'(DEF_BURST);
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            delay_q <= delay_d;
            burst_q <= burst_d;
            idx_q   <= idx_d;
            busy_q  <= state_d != ST_IDLE;
            done_q  <= done_d;
            trig_q  <= state_d == ST_HIGH;
        end
    end
    trig_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
        .i_clk  (i_clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .en_i   (!idle),
        .val_i  (load_val),
        .last_o (cnt_last)
    );
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.o_trig    = trig_q;
    assign bus.pulse_idx = idx_q;
endmodule

// File: tb/tb_trig_sequencer.sv
// tb_trig_sequencer: directed bench with a cycle-count model of the pulse train and per-cycle output checks
module tb_trig_sequencer;
    localparam int CW = 26;
    localparam int BW = 16;
    logic i_clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef TRIG_EXT_START_EN
    logic ext_trig = 1'b0;
    bit [2:0] m_ext = '0;
`endif
    trig_sequencer_if #(.CNT_W(CW), .BURST_W(BW)) bus();
    trig_sequencer #(.CNT_W(CW), .BURST_W(BW)) dut (
        .i_clk    (i_clk),
        .rst_n    (rst_n),
`ifdef TRIG_EXT_START_EN
        .ext_trig (ext_trig),
`endif
        .bus      (bus)
    );
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: run position m_c counts cycles since acceptance (1 on the accepting edge)
    longint sh_h, sh_p, sh_d, sh_n;
    longint m_c, m_h, m_p, m_d, m_n, e_idx;
    bit     m_run, e_done;
    initial forever begin
        @(posedge i_clk);
        if (!rst_n) begin
            sh_h = 1250000; sh_p = 2500000; sh_d = 0; sh_n = 0;
            m_run = 0; e_done = 0; e_idx = 0;
`ifdef TRIG_EXT_START_EN
            m_ext = '0;
`endif
        end else begin
            bit st;
            st = bus.start;
`ifdef TRIG_EXT_START_EN
            st = st | (m_ext[1] & ~m_ext[2]);
            m_ext = {m_ext[1:0], ext_trig};
`endif
            e_done = 0;
            if (m_run) begin
                if (bus.abort) m_run = 0;
                else begin
                    m_c++;
                    if (m_n != 0 && m_c > m_d + m_n * m_p) begin
                        m_run = 0;
                        e_done = 1;
                    end
                end
            end else begin
                if (bus.cfg_we) begin
                    sh_h = bus.cfg_high == 0 ? 1 : longint'(bus.cfg_high);
                    sh_p = longint'(bus.cfg_period) > sh_h ? longint'(bus.cfg_period) : sh_h + 1;
                    sh_d = bus.cfg_delay;
                    sh_n = bus.cfg_burst;
                end
                if (st && !bus.abort) begin
                    m_run = 1; m_c = 1; e_idx = 0;
                    m_h = sh_h; m_p = sh_p; m_d = sh_d; m_n = sh_n;
                end
            end
            if (m_run && m_c > m_d) e_idx = ((m_c - 1 - m_d) / m_p) % 65536;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge i_clk);
        if (rst_n) begin
            chk("busy", bus.busy, m_run);
            chk("done", bus.done, e_done);
            chk("o_trig", bus.o_trig, m_run && m_c > m_d && ((m_c - 1 - m_d) % m_p) < m_h);
            chk("pulse_idx", bus.pulse_idx, e_idx);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask
    task automatic cfg(input int p, input int h, input int d, input int n);
        bus.cfg_period = CW'(p); bus.cfg_high = CW'(h); bus.cfg_delay = CW'(d); bus.cfg_burst = BW'(n);
        bus.cfg_we = 1'b1;
        cyc(1);
        bus.cfg_we = 1'b0;
    endtask
    task automatic go();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_period = '0; bus.cfg_high = '0; bus.cfg_delay = '0;
        bus.cfg_burst = '0; bus.start = 0; bus.abort = 0;
        cyc(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_trig", bus.o_trig, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_idx", bus.pulse_idx, 0);
        rst_n = 1'b1;
        cyc(1);
        // finite burst: period 10, high 4, delay 3, 3 pulses
        cfg(10, 4, 3, 3);
        go();
        chk("fb_busy_c1", bus.busy, 1);
        cyc(2);
        chk("fb_trig_c3", bus.o_trig, 0);
        cyc(1);
        chk("fb_trig_c4", bus.o_trig, 1);
        cyc(3);
        chk("fb_trig_c7", bus.o_trig, 1);
        cyc(1);
        chk("fb_trig_c8", bus.o_trig, 0);
        cyc(16);
        chk("fb_trig_c24", bus.o_trig, 1);
        chk("fb_idx_c24", bus.pulse_idx, 2);
        cyc(9);
        chk("fb_busy_c33", bus.busy, 1);
        chk("fb_done_c33", bus.done, 0);
        cyc(1);
        chk("fb_done_c34", bus.done, 1);
        chk("fb_busy_c34", bus.busy, 0);
        cyc(1);
        chk("fb_done_c35", bus.done, 0);
        chk("fb_idx_hold", bus.pulse_idx, 2);
        // zero delay and clamping: H=1, P=2
        cfg(0, 0, 0, 3);
        go();
        chk("zc_trig_c1", bus.o_trig, 1);
        cyc(1);
        chk("zc_trig_c2", bus.o_trig, 0);
        cyc(1);
        chk("zc_trig_c3", bus.o_trig, 1);
        cyc(4);
        chk("zc_done_c7", bus.done, 1);
        cyc(2);
        // mid-pulse abort in continuous mode
        cfg(10, 4, 3, 0);
        go();
        cyc(15);
        chk("ab_trig_c16", bus.o_trig, 1);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        chk("ab_trig_c17", bus.o_trig, 0);
        chk("ab_busy_c17", bus.busy, 0);
        chk("ab_done_c17", bus.done, 0);
        cyc(3);
        // cfg_we and start while busy are ignored; later cfg_we applies to the next run
        cfg(10, 4, 0, 2);
        go();
        cyc(3);
        bus.cfg_period = CW'(20); bus.cfg_we = 1'b1; bus.start = 1'b1;
        cyc(1);
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        cyc(6);
        chk("rj_trig_c11", bus.o_trig, 1);
        cyc(10);
        chk("rj_done_c21", bus.done, 1);
        cyc(2);
        cfg(20, 4, 0, 1);
        go();
        cyc(10);
        chk("rj_busy_c11", bus.busy, 1);
        chk("rj_trig_c11b", bus.o_trig, 0);
        cyc(12);
        // reset mid-HIGH, then default config
        cfg(10, 4, 0, 0);
        go();
        cyc(2);
        chk("rs_trig_pre", bus.o_trig, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_trig_now", bus.o_trig, 0);
        chk("rs_busy_now", bus.busy, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        go();
        chk("df_trig_c1", bus.o_trig, 1);
        cyc(100);
        chk("df_trig_c101", bus.o_trig, 1);
        chk("df_busy_c101", bus.busy, 1);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        chk("df_busy_abort", bus.busy, 0);
        cyc(2);
`ifdef TRIG_EXT_START_EN
        cfg(10, 4, 0, 1);
        ext_trig = 1'b1;
        cyc(2);
        chk("ex_busy_c2", bus.busy, 0);
        cyc(1);
        chk("ex_busy_c3", bus.busy, 1);
        ext_trig = 1'b0;
        cyc(2);
        ext_trig = 1'b1;
        cyc(15);
        chk("ex_second_ignored", bus.busy, 0);
        ext_trig = 1'b0;
        cyc(3);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
